// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Constants shared by the fetch, program-counter and decode stages:
//   default PC/instruction widths and the fetch FSM state encoding.
//   The state encoding is a set of plain 2-bit localparams so that older
//   blocks that compare raw state codes keep working.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  // MSB index of every PC bus (PC buses are [DEFAULT_WIDTH:0])
  localparam int DEFAULT_WIDTH      = 11;
  // Instruction word width in bits
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] ST_ISSUE = 2'd0;  // strobe a read at pc
  localparam logic [1:0] ST_WAIT  = 2'd1;  // read in flight, wait for data
  localparam logic [1:0] ST_HOLD  = 2'd2;  // ir presented to decode
  localparam logic [1:0] ST_FLUSH = 2'd3;  // redirect in progress

  // A read is in flight while waiting for data, or while a flush still
  // expects the stale word of an abandoned read.
  function automatic logic read_outstanding(input logic [1:0] state,
                                            input logic       discard);
    return (state == ST_WAIT) || discard;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Drives the program counter (increment / load),
//   reads the instruction at pc from a single-outstanding-read memory and
//   presents it to decode through a valid/ready instruction register.
//   Redirects from execute reload the counter and abandon any fetch in
//   progress; a word already requested from memory is swallowed on return.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   pc                current program counter value
//   inc_pc, load_pc   one-cycle increment / load requests to the counter
//   pc_val            value loaded into the counter when load_pc=1
//   mem_rd, mem_addr  one-cycle read strobe and address to memory
//   mem_valid, mem_data  read return (any latency >= 1)
//   redirect, redirect_addr  one-cycle redirect request and target
//   ir, ir_valid, ir_ready   instruction register handshake to decode
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH:0]        pc,
  output logic                  inc_pc,
  output logic                  load_pc,
  output logic [WIDTH:0]        pc_val,
  output logic                  mem_rd,
  output logic [WIDTH:0]        mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [WIDTH:0]        redirect_addr,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_ready
);

  logic [1:0]            state_q,    state_d;
  logic                  inc_pc_q,   inc_pc_d;
  logic                  load_pc_q,  load_pc_d;
  logic [WIDTH:0]        pc_val_q,   pc_val_d;
  logic                  mem_rd_q,   mem_rd_d;
  logic [WIDTH:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] ir_q,       ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  discard_q,  discard_d;

  // Next-state logic: redirect overrides everything except reset.
  always_comb begin
    state_d    = state_q;
    inc_pc_d   = 1'b0;
    load_pc_d  = 1'b0;
    pc_val_d   = pc_val_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    discard_d  = discard_q;

    if (redirect) begin
      load_pc_d  = 1'b1;
      pc_val_d   = redirect_addr;
      ir_valid_d = 1'b0;
      state_d    = ST_FLUSH;
      // A word returning in this very cycle completes the read, so there
      // is nothing left to swallow afterwards.
      discard_d  = read_outstanding(state_q, discard_q) && !mem_valid;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          mem_rd_d   = 1'b1;
          mem_addr_d = pc;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_valid) begin
            ir_d       = mem_data;
            ir_valid_d = 1'b1;
            inc_pc_d   = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            state_d    = ST_WAIT;
          end
        end
        ST_HOLD: begin
          // HOLD always lasts at least one cycle, so the increment issued
          // on entry has reached the counter before the next ISSUE.
          if (ir_valid_q && ir_ready) begin
            ir_valid_d = 1'b0;
            state_d    = ST_ISSUE;
          end else begin
            state_d    = ST_HOLD;
          end
        end
        ST_FLUSH: begin
          if (discard_q) begin
            // Stale word is dropped; ir is left alone.
            if (mem_valid) begin
              discard_d = 1'b0;
            end else begin
              discard_d = 1'b1;
            end
          end else if (!load_pc_q) begin
            // Counter has held the target for a cycle: safe to fetch.
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d    = ST_ISSUE;
          ir_valid_d = 1'b0;
          discard_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ISSUE;
      inc_pc_q   <= 1'b0;
      load_pc_q  <= 1'b0;
      pc_val_q   <= {(WIDTH+1){1'b0}};
      mem_rd_q   <= 1'b0;
      mem_addr_q <= {(WIDTH+1){1'b0}};
      ir_q       <= {DATA_WIDTH{1'b0}};
      ir_valid_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inc_pc_q   <= inc_pc_d;
      load_pc_q  <= load_pc_d;
      pc_val_q   <= pc_val_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      discard_q  <= discard_d;
    end
  end

  assign inc_pc   = inc_pc_q;
  assign load_pc  = load_pc_q;
  assign pc_val   = pc_val_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Bench for fetch_unit with a behavioural program counter and a variable
//   latency instruction memory (mem[a] = a ^ 16'hA500). A scoreboard tracks
//   the address the next accepted instruction must come from: it advances by
//   one per accepted word and jumps to the target on each redirect.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          W       = 11;
  localparam logic [15:0] MEM_XOR = 16'hA500;

  logic          clk = 1'b0;
  logic          rst;
  logic [W:0]    pc;
  logic          inc_pc, load_pc, mem_rd, mem_valid, redirect, ir_valid, ir_ready;
  logic [W:0]    pc_val, mem_addr, redirect_addr;
  logic [15:0]   mem_data, ir;
  logic          inj;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_unit #(.WIDTH(W), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inc_pc(inc_pc), .load_pc(load_pc),
    .pc_val(pc_val), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data), .redirect(redirect),
    .redirect_addr(redirect_addr), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [W:0] a);
    return {4'h0, a} ^ MEM_XOR;
  endfunction

  // Program counter: load wins over increment, wraps at 12 bits.
  logic [W:0] ctr_q = '0;
  always @(posedge clk) begin
    if (rst)          ctr_q <= '0;
    else if (load_pc) ctr_q <= pc_val;
    else if (inc_pc)  ctr_q <= ctr_q + 12'd1;
  end
  assign pc = ctr_q;

  // Memory: data returns 'lat' cycles after the strobe; reset abandons it.
  int          lat   = 1;
  int          cnt_q = 0;
  logic        mv_q  = 1'b0;
  logic [15:0] md_q  = 16'h0;
  logic [W:0]  a_q   = '0;
  always @(posedge clk) begin
    if (rst) begin
      cnt_q <= 0;
      mv_q  <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      if (mem_rd) begin
        a_q <= mem_addr;
        if (lat <= 1) begin
          mv_q  <= 1'b1;
          md_q  <= mem_word(mem_addr);
          cnt_q <= 0;
        end else begin
          cnt_q <= lat - 1;
        end
      end else if (cnt_q == 1) begin
        mv_q  <= 1'b1;
        md_q  <= mem_word(a_q);
        cnt_q <= 0;
      end else if (cnt_q > 1) begin
        cnt_q <= cnt_q - 1;
      end
    end
  end
  assign mem_valid = mv_q | inj;
  assign mem_data  = inj ? 16'hDEAD : md_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  // Scoreboard / protocol state
  logic [W:0]  exp_pc    = '0;
  bit          outst     = 1'b0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_ir   = 16'h0;
  int viol_il = 0, viol_rd = 0, viol_st = 0;
  int inc_cnt = 0, load_cnt = 0, cyc_n = 0, acc_total = 0;
  logic [15:0] acc_q[$];
  int          acc_t[$];

  task automatic monitor();
    cyc_n++;
    if (rst) begin
      exp_pc    = '0;
      outst     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (inc_pc && load_pc) viol_il++;
      if (inc_pc)  inc_cnt++;
      if (load_pc) load_cnt++;
      if (prev_hold && !(ir_valid && ir == prev_ir)) viol_st++;
      if (mem_rd) begin
        if (outst) viol_rd++;
        check("fetch_addr", 32'(mem_addr), 32'(exp_pc));
      end
      if (mv_q)   outst = 1'b0;
      if (mem_rd) outst = 1'b1;
      if (redirect) begin
        exp_pc = redirect_addr;
      end else if (ir_valid && ir_ready) begin
        check("ir_word", 32'(ir), 32'(mem_word(exp_pc)));
        acc_q.push_back(ir);
        acc_t.push_back(cyc_n);
        acc_total++;
        exp_pc = exp_pc + 12'd1;
      end
      prev_hold = ir_valid && !ir_ready && !redirect;
      prev_ir   = ir;
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_rd(input int budget, input string tag);
    int k = 0;
    while (!mem_rd && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(mem_rd), 32'd1);
  endtask

  task automatic wait_irv(input int budget, input string tag);
    int k = 0;
    while (!ir_valid && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(ir_valid), 32'd1);
  endtask

  initial begin
    int bad;
    int rand_start;
    rst = 1'b1; redirect = 1'b0; redirect_addr = '0; ir_ready = 1'b0; inj = 1'b0; lat = 1;

    // 1: reset values, then first read at address 0
    cyc(); cyc();
    check("rst_ctrl", 32'({inc_pc, load_pc, mem_rd, ir_valid}), 32'h0);
    check("rst_pc_val", 32'(pc_val), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    rst = 1'b0;
    cyc();
    check("first_rd", 32'(mem_rd), 32'd1);
    check("first_addr", 32'(mem_addr), 32'h0);

    // 2: latency 1, decode always ready
    ir_ready = 1'b1; inc_cnt = 0; acc_q.delete(); acc_t.delete();
    wait_acc(3, 60, "t2_progress");
    if (acc_q.size() >= 3) begin
      check("t2_ir0", 32'(acc_q[0]), 32'hA500);
      check("t2_ir1", 32'(acc_q[1]), 32'hA501);
      check("t2_ir2", 32'(acc_q[2]), 32'hA502);
      check("t2_rate01", 32'(acc_t[1] - acc_t[0]), 32'd4);
      check("t2_rate12", 32'(acc_t[2] - acc_t[1]), 32'd4);
    end
    check("t2_inc_pulses", 32'(inc_cnt), 32'd3);
    check("t2_pc", 32'(pc), 32'd3);

    // 3: decode stalls on the second word
    do_reset();
    ir_ready = 1'b1; acc_q.delete();
    wait_acc(1, 30, "t3_first");
    ir_ready = 1'b0;
    wait_irv(20, "t3_irv");
    check("t3_ir", 32'(ir), 32'hA501);
    cyc();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (ir !== 16'hA501 || ir_valid !== 1'b1 || mem_rd !== 1'b0 || pc !== 12'd2) bad++;
      cyc();
    end
    check("t3_hold", 32'(bad), 32'd0);
    check("t3_pc", 32'(pc), 32'd2);

    // 4: redirect while a latency-3 read is in flight
    do_reset();
    lat = 3; ir_ready = 1'b1;
    wait_rd(10, "t4_rd");
    redirect = 1'b1; redirect_addr = 12'd261; inc_cnt = 0; load_cnt = 0;
    cyc();
    redirect = 1'b0;
    check("t4_load", 32'({inc_pc, load_pc}), 32'b01);
    check("t4_pc_val", 32'(pc_val), 32'd261);
    wait_irv(30, "t4_irv");
    check("t4_ir", 32'(ir), 32'hA405);
    check("t4_pc", 32'(pc), 32'd261);
    check("t4_no_inc", 32'(inc_cnt), 32'd0);
    check("t4_load_pulses", 32'(load_cnt), 32'd1);

    // 5: redirect to the top of the address space, PC wraps
    lat = 1;
    cyc();
    ir_ready = 1'b0; redirect = 1'b1; redirect_addr = 12'hFFF;
    cyc();
    redirect = 1'b0; ir_ready = 1'b1; acc_q.delete();
    wait_acc(1, 40, "t5_first");
    if (acc_q.size() >= 1) check("t5_ir_fff", 32'(acc_q[0]), 32'hAAFF);
    check("t5_pc_wrap", 32'(pc), 32'd0);
    wait_acc(2, 40, "t5_second");
    if (acc_q.size() >= 2) check("t5_ir_000", 32'(acc_q[1]), 32'hA500);
    check("t5_pc", 32'(pc), 32'd1);

    // 6: reset mid-read, then a late return that must be ignored
    lat = 4;
    wait_rd(20, "t6_rd");
    rst = 1'b1;
    cyc();
    inj = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    inj = 1'b0; lat = 1;
    check("t6_rd", 32'(mem_rd), 32'd1);
    check("t6_addr", 32'(mem_addr), 32'h0);
    check("t6_ir_untouched", 32'({ir_valid, ir}), 32'h0);
    acc_q.delete();
    wait_acc(1, 20, "t6_acc");
    if (acc_q.size() >= 1) check("t6_ir", 32'(acc_q[0]), 32'hA500);

    // Random traffic: latency, stalls and redirects
    rand_start = acc_total;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 6) begin
        redirect = 1'b1;
        if ($urandom_range(0, 1) == 1) redirect_addr = 12'(4095 - $urandom_range(0, 2));
        else                           redirect_addr = 12'($urandom_range(0, 4095));
        ir_ready = 1'b0;
      end else begin
        redirect = 1'b0;
        ir_ready = ($urandom_range(0, 99) < 65);
      end
      cyc();
    end
    redirect = 1'b0; ir_ready = 1'b1;
    repeat (20) cyc();
    check("rand_progress", 32'((acc_total - rand_start) >= 10), 32'd1);
    check("inc_load_excl", 32'(viol_il), 32'd0);
    check("rd_outstanding", 32'(viol_rd), 32'd0);
    check("ir_hold_stable", 32'(viol_st), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
